aes_decrypt: RTL and testbench

AES_DECRYPT -- requirements
Module: aes_decrypt

---
 rtl/aes_decrypt.sv | 267 ++++++++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// AES-128 inverse cipher, one step per clock: key schedule forward to K10,
// then nine inverse rounds and a final round.
// Ports:
//   clk, reset (async, active-high)
//   start    : decrypt request, sampled while idle
//   i_block  : 128-bit ciphertext
//   init_key : 128-bit cipher key (same key as for encryption)
//   o_block  : registered plaintext
//   block_finish : one-cycle pulse when o_block updates
//   busy     : high from accepted start until block_finish
module aes_decrypt #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] i_block,
  input  logic [127:0] init_key,
  output logic [127:0] o_block,
  output logic         block_finish,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    FINAL
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_reg_q, data_reg_d;
  logic [127:0] key_reg_q, key_reg_d;
  logic [127:0] o_block_q, o_block_d;
  logic         finish_q, finish_d;
  logic         busy_q, busy_d;

  // GF(2^8) multiply, polynomial 0x11b
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gmul(gmul(r, r), x);
    end
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]}
      ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]}
      ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    unique case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // SubWord(RotWord(w)) XOR Rcon(i) in the top byte
  function automatic logic [31:0] key_t(
    input logic [31:0] w,
    input logic [3:0]  i
  );
    logic [31:0] s;
    s = {sbox(w[23:16]), sbox(w[15:8]),
         sbox(w[7:0]),   sbox(w[31:24])};
    return s ^ {rcon(i), 24'h0};
  endfunction

  // Byte n lives at bits [127-8n -: 8]; row n%4, column n/4
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] d
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          d[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(
    input logic [127:0] d
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(d[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] d
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127-32*c -: 8];
      a1 = d[119-32*c -: 8];
      a2 = d[111-32*c -: 8];
      a3 = d[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  p0, p1, p2, p3;
  logic [3:0]   prev_idx;
  logic [127:0] key_fwd;
  logic [127:0] key_prev;
  logic [127:0] inv_core;
  logic [127:0] plain;

  assign kw0 = key_reg_q[127:96];
  assign kw1 = key_reg_q[95:64];
  assign kw2 = key_reg_q[63:32];
  assign kw3 = key_reg_q[31:0];

  // Forward expansion step toward K10
  assign f0      = kw0 ^ key_t(kw3, rnd_q);
  assign f1      = kw1 ^ f0;
  assign f2      = kw2 ^ f1;
  assign f3      = kw3 ^ f2;
  assign key_fwd = {f0, f1, f2, f3};

  // Undo one expansion step: K_rnd from K_(rnd+1); FINAL yields K0
  assign prev_idx = (state_q == FINAL) ? 4'd1 : rnd_q + 4'd1;
  assign p3       = kw3 ^ kw2;
  assign p2       = kw2 ^ kw1;
  assign p1       = kw1 ^ kw0;
  assign p0       = kw0 ^ key_t(p3, prev_idx);
  assign key_prev = {p0, p1, p2, p3};

  assign inv_core = inv_sub_bytes(inv_shift_rows(data_reg_q));
  assign plain    = inv_core ^ key_prev;

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    data_reg_d = data_reg_q;
    key_reg_d  = key_reg_q;
    o_block_d  = o_block_q;
    finish_d   = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_reg_d = i_block;
          key_reg_d  = init_key;
          rnd_d      = 4'd1;
          busy_d     = 1'b1;
          state_d    = KEYEXP;
        end
      end
      KEYEXP: begin
        key_reg_d = key_fwd;
        rnd_d     = rnd_q + 4'd1;
        if (rnd_q == 4'(NR)) begin
          rnd_d   = 4'(NR - 1);
          state_d = INIT;
        end
      end
      INIT: begin
        data_reg_d = data_reg_q ^ key_reg_q;
        state_d    = ROUND;
      end
      ROUND: begin
        key_reg_d  = key_prev;
        data_reg_d = inv_mix_columns(plain);
        rnd_d      = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        o_block_d  = plain;
        data_reg_d = plain;
        finish_d   = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rnd_q      <= 4'd0;
      data_reg_q <= '0;
      key_reg_q  <= '0;
      o_block_q  <= '0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      data_reg_q <= data_reg_d;
      key_reg_q  <= key_reg_d;
      o_block_q  <= o_block_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
    end
  end

  assign o_block      = o_block_q;
  assign block_finish = finish_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS-197 vectors, handshake,
// reset abort, and random round trips through a table-based encryptor.
module tb_aes_decrypt;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] i_block;
  logic [127:0] init_key;
  logic [127:0] o_block;
  logic         block_finish;
  logic         busy;

  int n_tests;
  int n_fail;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_decrypt #(.NR(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .i_block      (i_block),
    .init_key     (init_key),
    .o_block      (o_block),
    .block_finish (block_finish),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from a brute-force inverse search plus the affine map
  task automatic init_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
            ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook forward cipher on a byte array
  task automatic enc(input logic [127:0] key, input logic [127:0] pt,
                     output logic [127:0] ct);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [31:0] tmp;
    logic [7:0]  a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]}
            ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    ct = '0;
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Observations captured while a block runs
  logic         busy_k1;
  logic [127:0] ob_k5;
  logic [127:0] key_k10;

  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           output logic [127:0] res, output int lat);
    @(negedge clk);
    i_block  = ct;
    init_key = key;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1)  busy_k1 = busy;
      if (k == 5)  ob_k5   = o_block;
      if (k == 10) key_k10 = dut.key_reg_q;
      if (block_finish) begin
        lat = k;
        break;
      end
    end
    res = o_block;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_tests++;
    if (o_block !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_o_block got %h want 0", o_block);
    end
    n_tests++;
    if (block_finish !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_finish got %b want 0", block_finish);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_c1();
    logic [127:0] res;
    int lat;
    run_block(C1_KEY, C1_CT, res, lat);
    n_tests++;
    if (busy_k1 !== 1'b1) begin
      n_fail++;
      $display("FAIL c1_busy got %b want 1", busy_k1);
    end
    n_tests++;
    if (lat != 21) begin
      n_fail++;
      $display("FAIL c1_latency got %0d want 21", lat);
    end
    n_tests++;
    if (res !== C1_PT) begin
      n_fail++;
      $display("FAIL c1_result got %h want %h", res, C1_PT);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL c1_busy_end got %b want 0", busy);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (block_finish !== 1'b0) begin
      n_fail++;
      $display("FAIL c1_pulse_width got %b want 0", block_finish);
    end
  endtask

  task automatic test_b();
    logic [127:0] res;
    int lat;
    run_block(B_KEY, B_CT, res, lat);
    n_tests++;
    if (ob_k5 !== C1_PT) begin
      n_fail++;
      $display("FAIL b_hold got %h want %h", ob_k5, C1_PT);
    end
    n_tests++;
    if (key_k10 !== B_K10) begin
      n_fail++;
      $display("FAIL b_k10 got %h want %h", key_k10, B_K10);
    end
    n_tests++;
    if (lat != 21 || res !== B_PT) begin
      n_fail++;
      $display("FAIL b_result got %h lat %0d want %h lat 21", res, lat, B_PT);
    end
  endtask

  task automatic test_back_to_back();
    int f1, f2, gap;
    logic [127:0] r1, r2;
    f1 = -1; f2 = -1; gap = 0;
    r1 = '0; r2 = '0;
    @(negedge clk);
    i_block  = C1_CT;
    init_key = C1_KEY;
    start    = 1'b1;
    @(posedge clk);
    #1;
    i_block  = B_CT;
    init_key = B_KEY;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (f1 >= 0 && k == f1 + 1) start = 1'b0;
      if (f1 >= 0 && !busy && !block_finish) gap++;
      if (block_finish) begin
        if (f1 < 0) begin
          f1 = k; r1 = o_block;
        end else begin
          f2 = k; r2 = o_block;
          break;
        end
      end
    end
    start = 1'b0;
    n_tests++;
    if (f1 != 21 || r1 !== C1_PT) begin
      n_fail++;
      $display("FAIL b2b_first got %h at %0d want %h at 21", r1, f1, C1_PT);
    end
    n_tests++;
    if (f2 - f1 != 22 || r2 !== B_PT) begin
      n_fail++;
      $display("FAIL b2b_second got %h at %0d want %h at 43", r2, f2, B_PT);
    end
    n_tests++;
    if (gap != 0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap got %0d want 0", gap);
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] key, pt, ct, res;
    int lat, nfin;
    key = rnd128();
    pt  = rnd128();
    enc(key, pt, ct);
    lat = -1; nfin = 0; res = '0;
    @(negedge clk);
    i_block  = ct;
    init_key = key;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        start    = 1'b1;
        i_block  = rnd128();
        init_key = rnd128();
      end
      if (k == 6) start = 1'b0;
      if (block_finish) begin
        nfin++;
        if (lat < 0) begin
          lat = k; res = o_block;
        end
      end
    end
    n_tests++;
    if (lat != 21 || res !== pt) begin
      n_fail++;
      $display("FAIL busy_ignore got %h at %0d want %h at 21", res, lat, pt);
    end
    n_tests++;
    if (nfin != 1) begin
      n_fail++;
      $display("FAIL busy_ignore_count got %0d want 1", nfin);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat, nfin;
    nfin = 0;
    @(negedge clk);
    i_block  = C1_CT;
    init_key = C1_KEY;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (o_block !== 128'h0 || busy !== 1'b0 || block_finish !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %h/%b/%b want 0/0/0",
               o_block, busy, block_finish);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (block_finish) nfin++;
    end
    n_tests++;
    if (nfin != 0) begin
      n_fail++;
      $display("FAIL midreset_finish got %0d want 0", nfin);
    end
    run_block(C1_KEY, C1_CT, res, lat);
    n_tests++;
    if (lat != 21 || res !== C1_PT) begin
      n_fail++;
      $display("FAIL midreset_rerun got %h at %0d want %h at 21",
               res, lat, C1_PT);
    end
  endtask

  task automatic test_random();
    logic [127:0] key, pt, ct, res;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      key = rnd128();
      pt  = rnd128();
      enc(key, pt, ct);
      run_block(key, ct, res, lat);
      n_tests++;
      if (lat != 21 || res !== pt) begin
        n_fail++;
        $display("FAIL random_%0d got %h at %0d want %h at 21",
                 n, res, lat, pt);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    start    = 1'b0;
    i_block  = '0;
    init_key = '0;
    init_tables();
    test_reset();
    test_c1();
    test_b();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
